// File: rtl/dso_trig_capture.sv
// Triggered capture engine: hysteresis comparator, edge trigger, pre-trigger
// circular buffer, post-trigger fill and a trigger-aligned registered read port.
module dso_trig_capture #(
    parameter int INPUT_WIDTH  = 12,
    parameter int RAM_DEEP     = 1024,
    parameter int HYST         = 20,
    parameter int AUTO_TIMEOUT = 65536
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic [INPUT_WIDTH-1:0]      wave_in,
    input  logic [INPUT_WIDTH-1:0]      trig_value,
    input  logic                        trig_edge,
    input  logic [1:0]                  trig_mode,
    input  logic [$clog2(RAM_DEEP)-1:0] pre_depth,
    input  logic                        arm,
    input  logic                        rd_done,
    input  logic [$clog2(RAM_DEEP)-1:0] rd_addr,
    output logic [INPUT_WIDTH-1:0]      rd_data,
    output logic                        busy,
    output logic                        triggered,
    output logic                        forced,
    output logic                        done,
    output logic [2:0]                  dbg_state
);

    localparam int AW  = $clog2(RAM_DEEP);
    localparam int CW  = AW + 1;
    localparam int TW  = $clog2(AUTO_TIMEOUT);
    localparam int IW1 = INPUT_WIDTH + 1;
    localparam logic [IW1-1:0] MAXV       = {1'b0, {INPUT_WIDTH{1'b1}}};
    localparam logic [IW1-1:0] HYSTV      = IW1'(HYST);
    localparam logic [TW-1:0]  TCNT_LAST  = TW'(AUTO_TIMEOUT - 1);
    localparam logic [1:0]     MODE_SINGLE = 2'b01;
    localparam logic [1:0]     MODE_AUTO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state, w_next;
    logic [INPUT_WIDTH-1:0] r_ram [RAM_DEEP];
    logic [INPUT_WIDTH-1:0] r_d1, r_rd_data;
    logic                   r_cmp, r_cmp_d;
    logic [AW-1:0]          r_wr_ptr, r_trig_ptr, r_pre;
    logic [CW-1:0]          r_cnt;
    logic [TW-1:0]          r_tcnt;
    logic                   r_edge_sel, r_triggered, r_forced;
    logic [1:0]             r_mode_sel;

    logic [IW1-1:0] w_hi_raw, w_hi, w_lo, w_wave, w_tv;
    logic [CW-1:0]  w_post_total;
    logic [AW-1:0]  w_rd_ptr;
    logic           w_write, w_edge_ev, w_timeout, w_start, w_trig, w_force;

    // Thresholds are computed one bit wider so the clamps see the overflow.
    assign w_tv     = {1'b0, trig_value};
    assign w_wave   = {1'b0, wave_in};
    assign w_hi_raw = w_tv + HYSTV;
    assign w_hi     = (w_hi_raw > MAXV) ? MAXV : w_hi_raw;
    assign w_lo     = (w_tv < HYSTV) ? '0 : (w_tv - HYSTV);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp   <= 1'b0;
            r_cmp_d <= 1'b0;
            r_d1    <= '0;
        end else begin
            if (w_wave >= w_hi)
                r_cmp <= 1'b1;
            else if (w_wave <= w_lo)
                r_cmp <= 1'b0;
            r_cmp_d <= r_cmp;
            r_d1    <= wave_in;
        end
    end

    assign w_edge_ev    = r_edge_sel ? (r_cmp & ~r_cmp_d) : (~r_cmp & r_cmp_d);
    assign w_timeout    = (r_mode_sel == MODE_AUTO) && (r_tcnt == TCNT_LAST);
    assign w_post_total = CW'(RAM_DEEP) - {1'b0, r_pre};
    assign w_write      = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // arm wins everywhere; rd_done only re-arms a finished non-single capture.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_trig  = 1'b0;
        w_force = 1'b0;
        if (arm) begin
            w_start = 1'b1;
        end else begin
            case (r_state)
                S_PRE: begin
                    if (r_cnt + CW'(1) == {1'b0, r_pre})
                        w_next = S_WAIT;
                end
                S_WAIT: begin
                    if (w_edge_ev) begin
                        w_trig = 1'b1;
                    end else if (w_timeout) begin
                        w_trig  = 1'b1;
                        w_force = 1'b1;
                    end
                    if (w_trig)
                        w_next = (w_post_total == CW'(1)) ? S_DONE : S_POST;
                end
                S_POST: begin
                    if (r_cnt + CW'(1) == w_post_total)
                        w_next = S_DONE;
                end
                S_DONE: begin
                    if (rd_done && (r_mode_sel != MODE_SINGLE))
                        w_start = 1'b1;
                end
                default: w_next = r_state;
            endcase
        end
        if (w_start)
            w_next = (pre_depth == '0) ? S_WAIT : S_PRE;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_pre       <= '0;
            r_edge_sel  <= 1'b0;
            r_mode_sel  <= 2'b00;
            r_triggered <= 1'b0;
            r_forced    <= 1'b0;
        end else begin
            if (w_write)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_start) begin
                r_pre       <= pre_depth;
                r_edge_sel  <= trig_edge;
                r_mode_sel  <= trig_mode;
                r_cnt       <= '0;
                r_tcnt      <= '0;
                r_triggered <= 1'b0;
                r_forced    <= 1'b0;
            end else begin
                case (r_state)
                    S_PRE:  r_cnt <= (w_next == S_WAIT) ? '0 : r_cnt + CW'(1);
                    S_WAIT: begin
                        if (w_trig) begin
                            r_cnt       <= CW'(1);
                            r_trig_ptr  <= r_wr_ptr;
                            r_triggered <= 1'b1;
                            r_forced    <= w_force;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                    S_POST: r_cnt <= r_cnt + CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_write)
            r_ram[r_wr_ptr] <= r_d1;
    end

    // Logical index 0 is the oldest pre-trigger sample.
    assign w_rd_ptr = r_trig_ptr - r_pre + rd_addr;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            r_rd_data <= '0;
        else
            r_rd_data <= r_ram[w_rd_ptr];
    end

    assign rd_data   = r_rd_data;
    assign busy      = w_write;
    assign triggered = r_triggered;
    assign forced    = r_forced;
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dso_trig_capture.sv
// Directed bench for dso_trig_capture: 16-deep buffer, HYST=2, AUTO_TIMEOUT=8.
module tb_dso_trig_capture;

    localparam int IW = 12;
    localparam int RD = 16;
    localparam int AW = 4;

    localparam int ST_IDLE = 0;
    localparam int ST_PRE  = 1;
    localparam int ST_WAIT = 2;
    localparam int ST_POST = 3;
    localparam int ST_DONE = 4;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic [IW-1:0] wave_in, trig_value, rd_data;
    logic          trig_edge, arm, rd_done;
    logic [1:0]    trig_mode;
    logic [AW-1:0] pre_depth, rd_addr;
    logic          busy, triggered, forced, done;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n, k, post_at;

    dso_trig_capture #(
        .INPUT_WIDTH(IW), .RAM_DEEP(RD), .HYST(2), .AUTO_TIMEOUT(8)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .wave_in(wave_in), .trig_value(trig_value),
        .trig_edge(trig_edge), .trig_mode(trig_mode), .pre_depth(pre_depth),
        .arm(arm), .rd_done(rd_done), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .triggered(triggered), .forced(forced), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic read_chk(input string tag, input int idx, input int exp);
        rd_addr = AW'(idx);
        tick();
        check($sformatf("%s_idx%0d", tag, idx), int'(rd_data), exp);
    endtask

    task automatic status_chk(input string tag, input int b, input int t, input int f, input int d);
        check({tag, "_busy"}, int'(busy), b);
        check({tag, "_trig"}, int'(triggered), t);
        check({tag, "_forced"}, int'(forced), f);
        check({tag, "_done"}, int'(done), d);
    endtask

    initial begin
        rst_n = 1'b0; wave_in = '0; trig_value = 12'd100; trig_edge = 1'b1;
        trig_mode = 2'b01; pre_depth = 4'd4; arm = 1'b0; rd_done = 1'b0; rd_addr = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        status_chk("rst", 0, 0, 0, 0);
        check("rst_state", int'(dbg_state), ST_IDLE);
        check("rst_rd_data", int'(rd_data), 0);

        // 1: rising ramp, single mode, 4 pre-trigger samples
        repeat (3) tick();
        n = 0; k = 0; arm = 1'b1;
        while (!done && n < 100) begin
            wave_in = IW'(k * 10);
            tick();
            arm = 1'b0; k++; n++;
        end
        check("t1_latency", n, 24);
        status_chk("t1", 0, 1, 0, 1);
        for (int i = 0; i < RD; i++) read_chk("t1", i, 70 + 10 * i);

        // 2: toggling inside the hysteresis band must not trigger
        trig_mode = 2'b01; pre_depth = 4'd2; trig_edge = 1'b1;
        wave_in = '0; repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            wave_in = IW'((i % 2 == 0) ? 99 : 101);
            arm = (i == 0);
            tick();
        end
        arm = 1'b0;
        status_chk("t2_band", 1, 0, 0, 0);
        wave_in = IW'(105); tick();
        wave_in = IW'(50);
        n = 0;
        while (!done && n < 64) begin tick(); n++; end
        status_chk("t2_end", 0, 1, 0, 1);
        read_chk("t2", 0, 99);
        read_chk("t2", 1, 101);
        read_chk("t2", 2, 105);
        read_chk("t2", 3, 50);
        read_chk("t2", 15, 50);

        // 3: falling edge, normal mode, no pre-trigger, rd_done re-arm
        trig_edge = 1'b0; trig_mode = 2'b00; pre_depth = 4'd0;
        wave_in = IW'(200); repeat (3) tick();
        arm = 1'b1; tick(); arm = 1'b0;
        check("t3_arm_state", int'(dbg_state), ST_WAIT);
        repeat (4) tick();
        n = 0; k = 0;
        while (!done && n < 64) begin wave_in = IW'(50 - k); tick(); k++; n++; end
        status_chk("t3_end", 0, 1, 0, 1);
        read_chk("t3", 0, 50);
        read_chk("t3", 1, 49);
        read_chk("t3", 15, 35);
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        status_chk("t3_rearm", 1, 0, 0, 0);
        check("t3_rearm_state", int'(dbg_state), ST_WAIT);
        wave_in = IW'(200); repeat (3) tick();
        n = 0; k = 0;
        while (!done && n < 64) begin wave_in = IW'(60 - k); tick(); k++; n++; end
        status_chk("t3_end2", 0, 1, 0, 1);
        read_chk("t3b", 0, 60);
        read_chk("t3b", 9, 51);

        // 4: auto mode forces a trigger 8 cycles into WAIT_TRIG
        trig_edge = 1'b1; trig_mode = 2'b10; pre_depth = 4'd3;
        wave_in = IW'(5); repeat (3) tick();
        arm = 1'b1; tick(); arm = 1'b0;
        check("t4_arm_state", int'(dbg_state), ST_PRE);
        n = 1; post_at = 0;
        while (!done && n < 100) begin
            tick(); n++;
            if (n == 4) check("t4_wait_state", int'(dbg_state), ST_WAIT);
            if (int'(dbg_state) == ST_POST && post_at == 0) post_at = n;
        end
        check("t4_post_edge", post_at, 12);
        check("t4_done_edge", n, 24);
        status_chk("t4_end", 0, 1, 1, 1);
        read_chk("t4", 3, 5);

        // 5: arm during POST restarts; async reset mid WAIT_TRIG
        pre_depth = 4'd2;
        arm = 1'b1; tick(); arm = 1'b0;
        n = 0;
        while (int'(dbg_state) != ST_POST && n < 50) begin tick(); n++; end
        check("t5_post_after", n, 10);
        tick(); tick();
        check("t5_post_trig", int'(triggered), 1);
        arm = 1'b1; tick(); arm = 1'b0;
        check("t5_restart_state", int'(dbg_state), ST_PRE);
        status_chk("t5_restart", 1, 0, 0, 0);
        n = 0;
        while (int'(dbg_state) != ST_WAIT && n < 20) begin tick(); n++; end
        check("t5_wait_reached", int'(dbg_state), ST_WAIT);
        tick();
        rst_n = 1'b0;
        #1;
        status_chk("t5_rst", 0, 0, 0, 0);
        check("t5_rst_state", int'(dbg_state), ST_IDLE);
        check("t5_rst_rd_data", int'(rd_data), 0);
        tick();
        check("t5_rst_hold", int'(dbg_state), ST_IDLE);
        rst_n = 1'b1;

        // 6: full pre-trigger depth with wr_ptr wrapping
        trig_edge = 1'b1; trig_mode = 2'b01; pre_depth = 4'd15;
        wave_in = '0; repeat (3) tick();
        arm = 1'b1; tick(); arm = 1'b0;
        n = 1; k = 1;
        while (!done && n < 100) begin wave_in = IW'(5 * k); tick(); k++; n++; end
        check("t6_done_edge", n, 23);
        status_chk("t6_end", 0, 1, 0, 1);
        for (int i = 0; i < RD; i++) read_chk("t6", i, 30 + 5 * i);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "bench time limit");
    end

endmodule
